// File: rtl/pattern_step_ctrl.sv
// rtl/pattern_step_ctrl.sv - debounced pushbutton control and step pulse generation for the pattern sequencer
// Keys are synchronised, debounced and edge-detected; a RUN/PAUSE FSM gates a rate divider and single-step.
module pattern_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int STEP_DIV0       = 50_000_000,
    parameter int DIV_W           = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_pause,
    input  logic       key_step,
    input  logic       key_speed,
    output logic       step,
    output logic       running,
    output logic [1:0] speed
);

    localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   DEB_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W:0]  DIV0    = (DIV_W + 1)'(STEP_DIV0);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_PAUSE = 1'b1
    } state_t;

    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb_level;
    logic [2:0]    deb_prev;
    logic [2:0]    evt;
    logic [2:0]    armed;
    logic [1:0]    warm;
    logic [CW-1:0] deb_cnt [3];

    logic          pause_evt;
    logic          step_evt;
    logic          speed_evt;

    state_t           state_q;
    state_t           state_d;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_d;
    logic             step_d;
    logic [1:0]       speed_d;
    logic [DIV_W:0]   period;
    logic [DIV_W-1:0] term;

    assign raw       = {key_speed, key_step, key_pause};
    assign pause_evt = evt[0];
    assign step_evt  = evt[1];
    assign speed_evt = evt[2];

    // A key is only armed once the synchroniser has seen it released after reset,
    // so a button held low across reset release never yields a press event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= '1;
            sync2     <= '1;
            deb_level <= '1;
            deb_prev  <= '1;
            evt       <= '0;
            armed     <= '0;
            warm      <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            deb_prev <= deb_level;
            evt      <= deb_prev & ~deb_level & armed;
            warm     <= {warm[0], 1'b1};
            if (warm[1]) begin
                armed <= armed | sync2;
            end
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb_level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_MAX) begin
                    deb_level[i] <= sync2[i];
                    deb_cnt[i]   <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign period = DIV0 >> speed;
    assign term   = DIV_W'(period - (DIV_W + 1)'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            div_cnt <= '0;
            step    <= 1'b0;
            speed   <= 2'd1;
        end else begin
            state_q <= state_d;
            div_cnt <= div_d;
            step    <= step_d;
            speed   <= speed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_cnt;
        step_d  = 1'b0;
        speed_d = speed;
        case (state_q)
            S_RUN: begin
                if (div_cnt == term) begin
                    div_d  = '0;
                    step_d = 1'b1;
                end else begin
                    div_d = div_cnt + DIV_W'(1);
                end
                if (pause_evt) begin
                    state_d = S_PAUSE;
                    div_d   = '0;
                end
            end
            S_PAUSE: begin
                div_d = '0;
                // Leaving PAUSE swallows a coincident single-step request.
                if (pause_evt) begin
                    state_d = S_RUN;
                end else if (step_evt && !step) begin
                    step_d = 1'b1;
                end
            end
            default: begin
                state_d = S_RUN;
                div_d   = '0;
            end
        endcase
        if (speed_evt) begin
            speed_d = speed + 2'd1;
            div_d   = '0;
        end
    end

    assign running = (state_q == S_RUN);

endmodule

// File: tb/tb_pattern_step_ctrl.sv
// tb/tb_pattern_step_ctrl.sv - scoreboard bench for pattern_step_ctrl
module tb_pattern_step_ctrl;

    localparam int T0 = 5;

    logic       clk;
    logic       rst;
    logic       key_pause;
    logic       key_step;
    logic       key_speed;
    logic       step;
    logic       running;
    logic [1:0] speed;

    int cyc;
    int total;
    int bad;
    int exp_q[$];
    logic prev_step;

    pattern_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .STEP_DIV0      (64),
        .DIV_W          (7)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_pause(key_pause),
        .key_step (key_step),
        .key_speed(key_speed),
        .step     (step),
        .running  (running),
        .speed    (speed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_rel(input int t);
        while (cyc < T0 + t) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc - T0);
        end
    endtask

    task automatic push_steps(input int a, input int b, input int c, input int d, input int e);
        if (a > 0) exp_q.push_back(a);
        if (b > 0) exp_q.push_back(b);
        if (c > 0) exp_q.push_back(c);
        if (d > 0) exp_q.push_back(d);
        if (e > 0) exp_q.push_back(e);
    endtask

    // Monitor: every observed step pulse is matched against the next expected cycle.
    initial prev_step = 1'b0;
    always @(negedge clk) begin
        int e;
        if (step === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL step_unexpected: step at cycle %0d, none expected", cyc - T0);
            end else begin
                e = exp_q.pop_front();
                if (e != cyc - T0) begin
                    bad++;
                    $display("FAIL step_time: step at cycle %0d, expected cycle %0d", cyc - T0, e);
                end
            end
            if (prev_step === 1'b1) begin
                bad++;
                $display("FAIL step_back_to_back: step high on consecutive cycles at %0d, expected single", cyc - T0);
            end
        end
        prev_step = step;
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        key_pause = 1'b1;
        key_step  = 1'b1;
        key_speed = 1'b1;

        // Reset state and free-running at P=32
        wait_rel(0);
        check("reset_running", int'(running), 1);
        check("reset_speed", int'(speed), 1);
        check("reset_step", int'(step), 0);
        push_steps(32, 64, 96, 0, 0);
        rst = 1'b1;

        // Pause: press at 100 lands at 108
        wait_rel(100); key_pause = 1'b0;
        wait_rel(107); check("pause_not_yet", int'(running), 1);
        wait_rel(108); check("pause_taken", int'(running), 0);
        wait_rel(110); key_pause = 1'b1;

        // Single steps while paused, then a short glitch
        wait_rel(310); push_steps(328, 348, 368, 0, 0);
        wait_rel(320); key_step = 1'b0;
        wait_rel(330); key_step = 1'b1;
        wait_rel(340); key_step = 1'b0;
        wait_rel(350); key_step = 1'b1;
        wait_rel(360); key_step = 1'b0;
        wait_rel(370); key_step = 1'b1;
        wait_rel(380); key_step = 1'b0;
        wait_rel(382); key_step = 1'b1;

        // Resume at 408
        wait_rel(400); key_pause = 1'b0; push_steps(440, 0, 0, 0, 0);
        wait_rel(410); key_pause = 1'b1;

        // Speed changes at 458, 508, 548 (the last coincides with a terminal count)
        wait_rel(450); key_speed = 1'b0; push_steps(474, 490, 506, 0, 0);
        wait_rel(457); check("speed_before", int'(speed), 1);
        wait_rel(458); check("speed_to_2", int'(speed), 2);
        wait_rel(460); key_speed = 1'b1;
        wait_rel(500); key_speed = 1'b0; push_steps(516, 524, 532, 540, 548);
        wait_rel(508); check("speed_to_3", int'(speed), 3);
        wait_rel(510); key_speed = 1'b1;
        wait_rel(540); key_speed = 1'b0; push_steps(612, 676, 0, 0, 0);
        wait_rel(548); check("speed_wrap_0", int'(speed), 0);
        wait_rel(550); key_speed = 1'b1;

        // Pause lands on the terminal count at 676
        wait_rel(668); key_pause = 1'b0;
        wait_rel(675); check("tc_pause_before", int'(running), 1);
        wait_rel(676); check("tc_pause_after", int'(running), 0);
        wait_rel(678); key_pause = 1'b1;

        // Pause and speed together at 708
        wait_rel(700); key_pause = 1'b0; key_speed = 1'b0; push_steps(740, 772, 0, 0, 0);
        wait_rel(708);
        check("dual_running", int'(running), 1);
        check("dual_speed", int'(speed), 1);
        wait_rel(710); key_pause = 1'b1; key_speed = 1'b1;

        // Reset mid-count with the pause key held across release
        wait_rel(780); key_pause = 1'b0;
        wait_rel(782); rst = 1'b0;
        wait_rel(790); rst = 1'b1; push_steps(822, 854, 0, 0, 0);
        wait_rel(791);
        check("rst_running", int'(running), 1);
        check("rst_speed", int'(speed), 1);
        check("rst_step", int'(step), 0);
        wait_rel(829); check("held_key_no_event", int'(running), 1);
        wait_rel(830); key_pause = 1'b1;
        wait_rel(850); key_pause = 1'b0;
        wait_rel(857); check("repress_before", int'(running), 1);
        wait_rel(858); check("repress_pause", int'(running), 0);
        wait_rel(860); key_pause = 1'b1;

        wait_rel(920);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
